// File: rtl/itu_656_encoder.sv
// ITU-R BT.656 (525-line) byte-stream encoder: EAV/SAV code insertion, 80/10 blanking fill,
// and a one-word-per-request pull of YCbCr 4:2:2 pixels for the active region.
module itu_656_encoder #(
    parameter int H_ACTIVE     = 720,
    parameter int H_BLANK      = 268,
    parameter int V_TOTAL      = 525,
    parameter int V_ACT1_START = 19,
    parameter int V_BLK2_START = 263,
    parameter int V_ACT2_START = 282,
    parameter int F_CLR_LINE   = 3,
    parameter int F_SET_LINE   = 265
) (
    input  logic        iCLK_27,
    input  logic        iRST_N,
    input  logic        iEN,
    input  logic [15:0] iYCbCr,
    output logic        oREQ,
    output logic [7:0]  oTD_DATA,
    output logic        oH,
    output logic        oV,
    output logic        oF,
    output logic [9:0]  oLINE,
    output logic        oSOF
);
    localparam int SAV_POS    = 4 + H_BLANK;
    localparam int ACT_POS    = SAV_POS + 4;
    localparam int LINE_BYTES = ACT_POS + 2 * H_ACTIVE;
    localparam int PW         = $clog2(LINE_BYTES);

    localparam logic [PW-1:0] P_BLANK = PW'(4);
    localparam logic [PW-1:0] P_SAV   = PW'(SAV_POS);
    localparam logic [PW-1:0] P_ACT   = PW'(ACT_POS);
    localparam logic [PW-1:0] P_LAST  = PW'(LINE_BYTES - 1);
    localparam logic [9:0]    L_LAST  = 10'(V_TOTAL - 1);

    function automatic logic v_of(input logic [9:0] l);
        return (l < 10'(V_ACT1_START)) || ((l >= 10'(V_BLK2_START)) && (l < 10'(V_ACT2_START)));
    endfunction

    function automatic logic f_of(input logic [9:0] l);
        return !((l >= 10'(F_CLR_LINE)) && (l < 10'(F_SET_LINE)));
    endfunction

    function automatic logic [7:0] timing_byte(input logic [1:0] idx, input logic f, input logic v,
                                               input logic h);
        logic [7:0] b;
        b = 8'h00;
        if (idx == 2'd0) b = 8'hFF;
        if (idx == 2'd3) b = {1'b1, f, v, h, v ^ h, f ^ h, f ^ v, f ^ v ^ h};
        return b;
    endfunction

    // Keep 00/FF out of the active region so a sink never sees a false timing code.
    function automatic logic [7:0] clip(input logic [7:0] b);
        logic [7:0] r;
        r = b;
        if (b == 8'h00) r = 8'h01;
        if (b == 8'hFF) r = 8'hFE;
        return r;
    endfunction

    // p_q/line_q address the byte the next enabled edge will put on oTD_DATA.
    logic [PW-1:0] p_q, p_d;
    logic [9:0]    line_q, line_d, oline_q, oline_d;
    logic [7:0]    y_q, y_d, data_q, data_d;
    logic          req_q, req_d, h_q, h_d, v_q, v_d, f_q, f_d, sof_q, sof_d;
    logic          cur_v, cur_f;
    logic [1:0]    sav_idx;

    always_comb begin
        // NOTE: every target is given a default before any branch, so no path can infer a latch;
        // here the defaults are also the values a low iEN must force.
        p_d     = '0;
        line_d  = '0;
        oline_d = '0;
        y_d     = '0;
        data_d  = '0;
        req_d   = 1'b0;
        h_d     = 1'b0;
        v_d     = 1'b0;
        f_d     = 1'b0;
        sof_d   = 1'b0;
        cur_v   = v_of(line_q);
        cur_f   = f_of(line_q);
        sav_idx = 2'(p_q - P_SAV);

        if (iEN) begin
            p_d     = (p_q == P_LAST) ? '0 : p_q + PW'(1);
            line_d  = (p_q != P_LAST) ? line_q : ((line_q == L_LAST) ? '0 : line_q + 10'd1);
            oline_d = line_q;
            h_d     = p_q < P_SAV;
            v_d     = cur_v;
            f_d     = cur_f;
            sof_d   = (p_q == '0) && (line_q == '0);
            y_d     = y_q;

            if (p_q < P_BLANK) begin
                data_d = timing_byte(p_q[1:0], cur_f, cur_v, 1'b1);
            end else if (p_q < P_SAV) begin
                data_d = (p_q[0] ^ P_BLANK[0]) ? 8'h10 : 8'h80;
            end else if (p_q < P_ACT) begin
                data_d = timing_byte(sav_idx, cur_f, cur_v, 1'b0);
            end else if (cur_v) begin
                data_d = (p_q[0] ^ P_ACT[0]) ? 8'h10 : 8'h80;
            end else if (!(p_q[0] ^ P_ACT[0])) begin
                data_d = clip(iYCbCr[7:0]);
                y_d    = iYCbCr[15:8];
            end else begin
                data_d = clip(y_q);
            end

            // Request during the cycle before each chroma byte of a V=0 line.
            req_d = (p_d >= P_ACT) && !(p_d[0] ^ P_ACT[0]) && !v_of(line_d);
        end
    end

    always_ff @(posedge iCLK_27 or negedge iRST_N) begin
        if (!iRST_N) begin
            p_q     <= '0;
            line_q  <= '0;
            oline_q <= '0;
            y_q     <= '0;
            data_q  <= '0;
            req_q   <= 1'b0;
            h_q     <= 1'b0;
            v_q     <= 1'b0;
            f_q     <= 1'b0;
            sof_q   <= 1'b0;
        end else begin
            // NOTE: all state updates are non-blocking so every flop samples pre-edge values.
            p_q     <= p_d;
            line_q  <= line_d;
            oline_q <= oline_d;
            y_q     <= y_d;
            data_q  <= data_d;
            req_q   <= req_d;
            h_q     <= h_d;
            v_q     <= v_d;
            f_q     <= f_d;
            sof_q   <= sof_d;
        end
    end

    // A request is withdrawn the moment iEN falls, not one edge later.
    assign oREQ     = req_q & iEN;
    assign oTD_DATA = data_q;
    assign oH       = h_q;
    assign oV       = v_q;
    assign oF       = f_q;
    assign oLINE    = oline_q;
    assign oSOF     = sof_q;
endmodule

// File: tb/tb_itu_656_encoder.sv
// Self-checking bench for itu_656_encoder with a shortened line (default vertical timing);
// active bytes are checked against a scoreboard filled as source words are handed over.
module tb_itu_656_encoder;
    localparam int HA    = 16;
    localparam int HB    = 12;
    localparam int SAV_P = 4 + HB;
    localparam int ACT_P = SAV_P + 4;
    localparam int LB    = ACT_P + 2 * HA;
    localparam int VT    = 525;

    logic        clk = 1'b0;
    logic        rst_n, en;
    logic [15:0] ycbcr;
    logic        req, h_o, v_o, f_o, sof_o;
    logic [7:0]  td;
    logic [9:0]  line_o;

    int         vectors = 0;
    int         miscompares = 0;
    logic [7:0] exp_q[$];
    int         mp, ml, n_word;
    bit         run;

    itu_656_encoder #(.H_ACTIVE(HA), .H_BLANK(HB)) dut (
        .iCLK_27(clk), .iRST_N(rst_n), .iEN(en), .iYCbCr(ycbcr), .oREQ(req),
        .oTD_DATA(td), .oH(h_o), .oV(v_o), .oF(f_o), .oLINE(line_o), .oSOF(sof_o)
    );

    always #5 clk = ~clk;

    function automatic bit m_v(input int l);
        return (l < 19) || (l >= 263 && l < 282);
    endfunction

    function automatic bit m_f(input int l);
        return !(l >= 3 && l < 265);
    endfunction

    function automatic logic [7:0] m_clip(input logic [7:0] b);
        if (b == 8'h00) return 8'h01;
        if (b == 8'hFF) return 8'hFE;
        return b;
    endfunction

    function automatic logic [7:0] m_code(input int idx, input int l, input bit h);
        bit f, v;
        f = m_f(l);
        v = m_v(l);
        if (idx == 0) return 8'hFF;
        if (idx == 3) return {1'b1, f, v, h, v ^ h, f ^ h, f ^ v, f ^ v ^ h};
        return 8'h00;
    endfunction

    // Expected byte at any position that is not a pixel byte.
    function automatic logic [7:0] m_byte(input int p, input int l);
        if (p < 4) return m_code(p, l, 1'b1);
        if (p < SAV_P) return ((p - 4) % 2 != 0) ? 8'h10 : 8'h80;
        if (p < ACT_P) return m_code(p - SAV_P, l, 1'b0);
        return ((p - ACT_P) % 2 != 0) ? 8'h10 : 8'h80;
    endfunction

    function automatic bit m_req(input int p, input int l);
        return (p + 1 >= ACT_P) && (p + 1 < LB) && ((p + 1 - ACT_P) % 2 == 0) && !m_v(l);
    endfunction

    // Hand-derived XY codes for the lines the frame test spot-checks.
    function automatic logic [7:0] k_code(input int l, input bit eav);
        case (l)
            0:   return eav ? 8'hF1 : 8'hEC;
            19:  return eav ? 8'h9D : 8'h80;
            263: return eav ? 8'hB6 : 8'hAB;
            default: return eav ? 8'hDA : 8'hC7;
        endcase
    endfunction

    // One clock: advance the position model and serve any pending pixel request.
    task automatic tick();
        bit e, r;
        logic [7:0] lo, hi;
        e = en;
        r = rst_n;
        @(posedge clk);
        #1;
        if (!e || !r) run = 0;
        else if (!run) begin
            run = 1; mp = 0; ml = 0;
        end else if (mp == LB - 1) begin
            mp = 0; ml = (ml == VT - 1) ? 0 : ml + 1;
        end else mp++;
        if (req === 1'b1) begin
            lo = n_word[7:0];
            hi = lo + 8'h20;
            ycbcr = {hi, lo};
            exp_q.push_back(m_clip(lo));
            exp_q.push_back(m_clip(hi));
            n_word++;
        end else ycbcr = 16'($urandom);
    endtask

    task automatic test_start_codes(input string tag);
        logic [7:0] want[4];
        want[0] = 8'hFF; want[1] = 8'h00; want[2] = 8'h00; want[3] = 8'hF1;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) tick();
            vectors++;
            if (td !== want[i]) begin
                miscompares++;
                $display("FAIL %s_byte%0d: got %h expected %h", tag, i, td, want[i]);
            end
            vectors++;
            if (sof_o !== (i == 0) || line_o !== 10'd0) begin
                miscompares++;
                $display("FAIL %s_sof_line%0d: got sof=%b line=%0d expected sof=%b line=0", tag, i,
                         sof_o, line_o, i == 0);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b0; ycbcr = '0; run = 0; n_word = 0; mp = 0; ml = 0;
        exp_q.delete();
        tick();
        tick();
        vectors++;
        if ({td, req, h_o, v_o, f_o, line_o, sof_o} !== 23'd0) begin
            miscompares++;
            $display("FAIL reset_state: got td=%h req=%b hvf=%b%b%b line=%0d sof=%b expected all zero",
                     td, req, h_o, v_o, f_o, line_o, sof_o);
        end
        rst_n = 1'b1;
        tick();
        vectors++;
        if (td !== 8'h00 || sof_o !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_after_release: got td=%h sof=%b expected 00/0", td, sof_o);
        end
    endtask

    task automatic test_first_line();
        int reqs;
        en = 1'b1;
        tick();
        test_start_codes("first");
        reqs = 0;
        for (int p = 4; p < LB; p++) begin
            tick();
            if (req === 1'b1) reqs++;
            vectors++;
            if (td !== m_byte(mp, ml) || mp != p) begin
                miscompares++;
                $display("FAIL line0_p%0d: got %h expected %h", p, td, m_byte(p, 0));
            end
            if (p == SAV_P + 3) begin
                vectors++;
                if (td !== 8'hEC) begin
                    miscompares++;
                    $display("FAIL line0_sav_xy: got %h expected ec", td);
                end
            end
        end
        vectors++;
        if (reqs != 0) begin
            miscompares++;
            $display("FAIL line0_req_count: got %0d expected 0", reqs);
        end
    endtask

    task automatic test_frame();
        int sof_cnt, reqs;
        logic [9:0] prev_line;
        logic [7:0] want;
        bit done;
        sof_cnt = 0; reqs = 0; done = 0;
        prev_line = line_o;
        for (int c = 0; c < VT * LB + 10 && !done; c++) begin
            tick();
            if (mp >= ACT_P && !m_v(ml)) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL scoreboard_empty: line %0d p %0d got %h expected a queued pixel", ml, mp, td);
                end else begin
                    want = exp_q.pop_front();
                    if (td !== want) begin
                        miscompares++;
                        $display("FAIL pixel_l%0d_p%0d: got %h expected %h", ml, mp, td, want);
                    end
                end
            end else begin
                vectors++;
                if (td !== m_byte(mp, ml)) begin
                    miscompares++;
                    $display("FAIL byte_l%0d_p%0d: got %h expected %h", ml, mp, td, m_byte(mp, ml));
                end
            end
            vectors++;
            if ({h_o, v_o, f_o} !== {mp < SAV_P, m_v(ml), m_f(ml)} || line_o !== 10'(ml)) begin
                miscompares++;
                $display("FAIL flags_l%0d_p%0d: got hvf=%b%b%b line=%0d expected hvf=%b%b%b line=%0d",
                         ml, mp, h_o, v_o, f_o, line_o, mp < SAV_P, m_v(ml), m_f(ml), ml);
            end
            vectors++;
            if (sof_o !== (mp == 0 && ml == 0) || req !== m_req(mp, ml)) begin
                miscompares++;
                $display("FAIL sof_req_l%0d_p%0d: got sof=%b req=%b expected sof=%b req=%b",
                         ml, mp, sof_o, req, mp == 0 && ml == 0, m_req(mp, ml));
            end
            if (sof_o === 1'b1) sof_cnt++;
            if (req === 1'b1) reqs++;
            if ((mp == 3 || mp == SAV_P + 3) && ml inside {0, 19, 263, 282}) begin
                vectors++;
                if (td !== k_code(ml, mp == 3)) begin
                    miscompares++;
                    $display("FAIL xy_l%0d_%s: got %h expected %h", ml, mp == 3 ? "eav" : "sav", td,
                             k_code(ml, mp == 3));
                end
            end
            if ((ml == 19 && mp == ACT_P) || (ml == 34 && mp == ACT_P + 30) ||
                (ml == 32 && mp == ACT_P + 31) || (ml == 33 && mp == ACT_P + 1)) begin
                want = (ml == 19 || ml == 33) ? 8'h01 : 8'hFE;
                vectors++;
                if (td !== want) begin
                    miscompares++;
                    $display("FAIL clip_l%0d_p%0d: got %h expected %h", ml, mp, td, want);
                end
            end
            if (mp == LB - 1) begin
                vectors++;
                if (reqs != (m_v(ml) ? 0 : HA)) begin
                    miscompares++;
                    $display("FAIL req_count_l%0d: got %0d expected %0d", ml, reqs, m_v(ml) ? 0 : HA);
                end
                reqs = 0;
            end
            if (mp == 0 && ml == 0) begin
                vectors++;
                if (prev_line !== 10'd524) begin
                    miscompares++;
                    $display("FAIL line_wrap: got previous line %0d expected 524", prev_line);
                end
            end
            if (mp == 3 && ml == 0) done = 1;
            prev_line = line_o;
        end
        vectors++;
        if (!done || sof_cnt != 1) begin
            miscompares++;
            $display("FAIL frame_sof: got %0d pulses (done=%b) expected 1", sof_cnt, done);
        end
    endtask

    task automatic run_to(input int l, input int p, input string tag);
        bit hit;
        hit = 0;
        for (int c = 0; c < 2 * VT * LB && !hit; c++) begin
            tick();
            if (ml == l && mp == p) hit = 1;
        end
        vectors++;
        if (!hit) begin
            miscompares++;
            $display("FAIL %s_timeout: got no arrival expected line %0d p %0d", tag, l, p);
        end
    endtask

    task automatic test_enable_drop();
        en = 1'b0;
        tick();
        exp_q.delete();
        en = 1'b1;
        run_to(19, ACT_P + 9, "drop");
        vectors++;
        if (req !== 1'b1) begin
            miscompares++;
            $display("FAIL drop_pre_req: got %b expected 1", req);
        end
        en = 1'b0;
        #1;
        vectors++;
        if (req !== 1'b0) begin
            miscompares++;
            $display("FAIL drop_req_gated: got %b expected 0", req);
        end
        tick();
        exp_q.delete();
        vectors++;
        if ({td, req, h_o, v_o, f_o, line_o, sof_o} !== 23'd0) begin
            miscompares++;
            $display("FAIL drop_outputs: got td=%h req=%b hvf=%b%b%b line=%0d expected all zero",
                     td, req, h_o, v_o, f_o, line_o);
        end
        tick();
        vectors++;
        if (td !== 8'h00 || req !== 1'b0) begin
            miscompares++;
            $display("FAIL drop_hold: got td=%h req=%b expected 00/0", td, req);
        end
        en = 1'b1;
        tick();
        test_start_codes("reenable");
    endtask

    task automatic test_async_reset();
        run_to(19, ACT_P + 5, "areset");
        #1;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({td, req, h_o, v_o, f_o, line_o, sof_o} !== 23'd0) begin
            miscompares++;
            $display("FAIL areset_immediate: got td=%h req=%b hvf=%b%b%b line=%0d expected all zero",
                     td, req, h_o, v_o, f_o, line_o);
        end
        tick();
        exp_q.delete();
        tick();
        rst_n = 1'b1;
        tick();
        test_start_codes("areset");
    endtask

    initial begin
        test_reset();
        test_first_line();
        test_frame();
        test_enable_drop();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
